// File: rtl/gcd_engine.sv
// gcd_engine: handshaked GCD unit, subtractive (Euclid) or binary (Stein) selected per operation.
// One operation in flight; the result is held in DONE until the consumer takes it.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for an operand pair
//  CALC  | one reduction step (or termination) per cycle, iteration count running
//  DONE  | out_valid high, result held until out_ready
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [KW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             term;
    logic [WIDTH-1:0] res;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        cyc_d   = cyc_q;
        term    = 1'b0;
        res     = '0;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    mode_d  = in_mode;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_inc;
                // k stays zero in subtractive mode, so the shift is harmless there
                if (a_q == '0) begin
                    term = 1'b1;
                    res  = b_q << k_q;
                end else if (b_q == '0 || a_q == b_q) begin
                    term = 1'b1;
                    res  = a_q << k_q;
                end else if (!mode_q) begin
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
                if (term) begin
                    gcd_d   = res;
                    cyc_d   = cnt_inc;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            cyc_q   <= cyc_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_gcd    = gcd_q;
    assign out_cycles = cyc_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: directed cases with literal expectations plus randomized pairs,
// checked every cycle against a behavioural model (two instances: CNT_W=16 and CNT_W=8).
module tb_gcd_engine;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_mode = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready, out_valid, in_ready8, out_valid8;
    logic [W-1:0]  out_gcd, out_gcd8;
    logic [15:0]   out_cycles;
    logic [7:0]    out_cycles8;

    gcd_engine #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_gcd(out_gcd), .out_cycles(out_cycles)
    );

    gcd_engine #(.WIDTH(W), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid8),
        .out_ready(out_ready), .out_gcd(out_gcd8), .out_cycles(out_cycles8)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned g;
        int          steps;
        int          acc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic abort(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // Mathematical GCD, independent of either algorithm
    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of CALC cycles the selected algorithm's rules take, terminating cycle included
    function automatic int ref_steps(input int unsigned a, input int unsigned b, input bit mode);
        int unsigned x = a, y = b;
        int n = 0;
        bit fin = 0;
        while (!fin) begin
            n++;
            if (x == 0 || y == 0 || x == y) fin = 1;
            else if (!mode) begin
                if (x > y) x = x - y; else y = y - x;
            end else if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2; y = y / 2;
            end else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
        return n;
    endfunction

    bit just_reset = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            just_reset = 1;
        end else begin
            bit   exp_ready;
            bit   exp_valid;
            int   s16, s8;
            exp_t e;
            exp_ready = (q.size() == 0);
            exp_valid = 0;
            if (!exp_ready) exp_valid = ((cyc - q[0].acc) >= q[0].steps + 1);
            check("in_ready", in_ready, exp_ready);
            check("in_ready8", in_ready8, exp_ready);
            check("out_valid", out_valid, exp_valid);
            check("out_valid8", out_valid8, exp_valid);
            if (just_reset) begin
                check("rst_gcd", out_gcd, 0);
                check("rst_cycles", out_cycles, 0);
                check("rst_cycles8", out_cycles8, 0);
                just_reset = 0;
            end
            if (exp_valid) begin
                s16 = (q[0].steps > 65535) ? 65535 : q[0].steps;
                s8  = (q[0].steps > 255) ? 255 : q[0].steps;
                check("gcd", out_gcd, q[0].g);
                check("cycles", out_cycles, s16);
                check("gcd8", out_gcd8, q[0].g);
                check("cycles8", out_cycles8, s8);
            end
            if (exp_ready && in_valid) begin
                e.g     = ref_gcd(in_a, in_b);
                e.steps = ref_steps(in_a, in_b, in_mode);
                e.acc   = cyc;
                q.push_back(e);
            end else if (exp_valid && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    int          acc_cyc;
    logic [W-1:0] last_g;
    logic [15:0] last_c;
    logic [7:0]  last_c8;
    int          last_lat;

    // Called half a cycle-ish after a rising edge; returns at the same phase after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int n = 0;
        bit taken = 0;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        while (!taken) begin
            @(negedge clk);
            if (in_ready) begin
                taken   = 1;
                acc_cyc = cyc;
            end else if (++n > 100) abort("send_wait");
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget, input bit noisy);
        int n = 0;
        bit got = 0;
        while (!got) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got      = 1;
                last_g   = out_gcd;
                last_c   = out_cycles;
                last_c8  = out_cycles8;
                last_lat = cyc - acc_cyc;
            end else begin
                if (++n > budget) abort("result_wait");
                @(posedge clk); #1;
                if (noisy) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_valid  = $urandom_range(0, 1);
                    in_a      = W'($urandom);
                    in_b      = W'($urandom);
                    in_mode   = $urandom_range(0, 1);
                end
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input int eg, input int ec, input int budget);
        send(a, b, m);
        wait_result(budget, 0);
        check("dir_gcd", last_g, eg);
        check("dir_cycles", last_c, ec);
        check("dir_cycles8", last_c8, (ec > 255) ? 255 : ec);
        check("dir_latency", last_lat, ec + 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int wa, wb;
        int n;

        // pin the model with hand-derived values
        check("model_sub_12_18", ref_steps(12, 18, 0), 3);
        check("model_bin_12_18", ref_steps(12, 18, 1), 4);
        check("model_bin_48_180", ref_steps(48, 180, 1), 8);
        check("model_gcd_48_180", ref_gcd(48, 180), 12);
        check("model_gcd_0_7", ref_gcd(0, 7), 7);
        check("model_sub_max", ref_steps(65535, 1, 0), 65535);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(12, 18, 0, 6, 3, 100);
        run(12, 18, 1, 6, 4, 100);
        run(48, 180, 1, 12, 8, 100);
        for (int m = 0; m < 2; m++) begin
            run(0, 7, m[0], 7, 1, 100);
            run(9, 0, m[0], 9, 1, 100);
            run(0, 0, m[0], 0, 1, 100);
        end
        run(35, 21, 1, 7, ref_steps(35, 21, 1), 100);

        // long subtractive run: exact count on 16 bits, saturated on 8 bits
        run(65535, 1, 0, 1, 65535, 70000);

        // back-pressure in DONE with in_valid pulses that must be ignored
        out_ready = 1'b0;
        send(12, 18, 0);
        n = 0;
        do begin
            @(negedge clk);
            if (++n > 50) abort("bp_wait");
        end while (!out_valid);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = i[0];
            in_a     = W'(i + 3);
            in_b     = W'(i + 5);
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_gcd", out_gcd, 6);
            check("bp_cycles", out_cycles, 3);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        @(posedge clk); #1;

        // reset in the middle of a long calculation
        send(65535, 1, 0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_gcd", out_gcd, 0);
        check("mid_rst_cycles", out_cycles, 0);
        @(posedge clk); #1;
        run(35, 21, 0, 7, 4, 100);

        // randomized pairs; the per-cycle compare process checks them against the model
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) begin
                ra = W'($urandom_range(0, 31));
                rb = W'($urandom_range(0, 31));
            end else begin
                wa = $urandom_range(1, 12);
                wb = $urandom_range(1, 12);
                ra = W'($urandom_range(0, (1 << wa) - 1));
                rb = W'($urandom_range(0, (1 << wb) - 1));
            end
            send(ra, rb, i[0]);
            wait_result(5000, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
